// File: rtl/rv_ddr_arb.sv
// rtl/rv_ddr_arb.sv - two-port round-robin cache-line arbiter in front of a DDR3 MIG app interface
// One transaction in flight; a read returns one line, a write is one command plus one wdf beat.
module rv_ddr_arb #(
   parameter int AW  = 28,
   parameter int DW  = 128,
   parameter int TMO = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            calib_done,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_done,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wmask,
   output logic            d_done,
   output logic [DW-1:0]   d_rdata,
   output logic [AW-1:0]   app_addr,
   output logic [2:0]      app_cmd,
   output logic            app_en,
   input  logic            app_rdy,
   output logic [DW-1:0]   app_wdf_data,
   output logic [DW/8-1:0] app_wdf_mask,
   output logic            app_wdf_wren,
   output logic            app_wdf_end,
   input  logic            app_wdf_rdy,
   input  logic [DW-1:0]   app_rd_data,
   input  logic            app_rd_data_valid,
   output logic            tmo_err
);

   localparam int         CW     = $clog2(TMO);
   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RCMD, S_RWAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              owner_q, owner_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW/8-1:0]   wmask_q, wmask_d;
   logic              cmd_ok_q, cmd_ok_d;
   logic              wdf_ok_q, wdf_ok_d;
   logic [CW-1:0]     wdog_q, wdog_d;
   logic [DW-1:0]     i_rdata_q, i_rdata_d;
   logic [DW-1:0]     d_rdata_q, d_rdata_d;
   logic              tmo_q, tmo_d;
   logic              pick_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_d_q  <= 1'b1;
         owner_q   <= 1'b0;
         addr_q    <= '0;
         cmd_q     <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         cmd_ok_q  <= 1'b0;
         wdf_ok_q  <= 1'b0;
         wdog_q    <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         cmd_q     <= cmd_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         cmd_ok_q  <= cmd_ok_d;
         wdf_ok_q  <= wdf_ok_d;
         wdog_q    <= wdog_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      cmd_ok_d  = cmd_ok_q;
      wdf_ok_d  = wdf_ok_q;
      wdog_d    = wdog_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      tmo_d     = tmo_q;
      pick_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (calib_done && (i_req || d_req)) begin
               // D wins only when I is idle or I was the last one served
               pick_d   = d_req && (!i_req || !last_d_q);
               owner_d  = pick_d;
               addr_d   = pick_d ? d_addr : i_addr;
               cmd_d    = (pick_d && d_we) ? CMD_WR : CMD_RD;
               cmd_ok_d = 1'b0;
               wdf_ok_d = 1'b0;
               if (pick_d && d_we) begin
                  wdata_d = d_wdata;
                  wmask_d = ~d_wmask;
                  state_d = S_WR;
               end else begin
                  state_d = S_RCMD;
               end
            end
         end
         S_WR: begin
            // command and data channels retire independently
            if (app_rdy)     cmd_ok_d = 1'b1;
            if (app_wdf_rdy) wdf_ok_d = 1'b1;
            if (cmd_ok_d && wdf_ok_d) state_d = S_DONE;
         end
         S_RCMD: begin
            if (app_rdy) begin
               wdog_d  = '0;
               state_d = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (app_rd_data_valid) begin
               if (owner_q) d_rdata_d = app_rd_data;
               else         i_rdata_d = app_rd_data;
               state_d = S_DONE;
            end else if (wdog_q == CW'(TMO - 1)) begin
               tmo_d = 1'b1;
               if (owner_q) d_rdata_d = '0;
               else         i_rdata_d = '0;
               state_d = S_DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_DONE: begin
            last_d_d = owner_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign app_en       = (state_q == S_RCMD) || ((state_q == S_WR) && !cmd_ok_q);
   assign app_wdf_wren = (state_q == S_WR) && !wdf_ok_q;
   assign app_wdf_end  = app_wdf_wren;
   assign app_addr     = addr_q;
   assign app_cmd      = cmd_q;
   assign app_wdf_data = wdata_q;
   assign app_wdf_mask = wmask_q;
   assign i_done       = (state_q == S_DONE) && !owner_q;
   assign d_done       = (state_q == S_DONE) && owner_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign tmo_err      = tmo_q;

endmodule
